// File: rtl/z_pack.sv
// z_pack: serial-to-parallel packer building the 66-bit operand word z from
// four field beats (7, 13, 13 and 33 bits, most significant field first).
// An assembly register plus an output register let the next word be collected
// while the current one waits for the downstream stage.
//
// Optional feature macro: Z_PACK_RANGE_CHK_EN
//   defined     -> accepted beats with nonzero bits above the field width set
//                  the sticky err flag (cleared by clr or reset).
//   not defined -> err is tied to 0 and out-of-range bits are dropped silently.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1; valid, once raised, holds its data until that edge, and ready never
// depends combinationally on the valid of the same interface.

`ifndef Datawidth
`define Datawidth 32
`endif

module z_pack (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [`Datawidth:0]        in_data,
   output logic [2*`Datawidth+1:0]    z,
   output logic                       z_valid,
   input  logic                       z_ready,
   output logic                       err,
   output logic                       dbg_full,
   output logic [1:0]                 dbg_cnt
);

   localparam int DW = `Datawidth;
   localparam int ZW = 2 * DW + 2;

   // Field placement inside z, beat0 lands in the top bits.
   localparam int F3_HI = DW;
   localparam int F2_LO = DW + 1;
   localparam int F2_HI = DW + 13;
   localparam int F1_LO = DW + 14;
   localparam int F1_HI = DW + 26;
   localparam int F0_LO = DW + 27;
   localparam int F0_HI = ZW - 1;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t          state;
   logic [1:0]      cnt;
   logic [ZW-1:0]   asm_q;
   logic [ZW-1:0]   word_done;
   logic            accept;
   logic            drain;

   // Ready depends only on registered state and the flush request.
   assign in_ready  = (state == COLLECT) && !clr;
   assign accept    = in_valid && in_ready;
   assign drain     = z_valid && z_ready;
   assign word_done = {asm_q[F0_HI:F2_LO], in_data[F3_HI:0]};

   assign dbg_full  = (state == FULL);
   assign dbg_cnt   = cnt;

   // Beat collection, FULL stall handling and output register in one FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= COLLECT;
         cnt     <= 2'd0;
         asm_q   <= '0;
         z       <= '0;
         z_valid <= 1'b0;
      end else begin
         // A consumed word empties the output unless a new one replaces it below.
         if (drain) begin
            z_valid <= 1'b0;
         end
         if (clr) begin
            // Flush drops the partial or held word but never the output word.
            state <= COLLECT;
            cnt   <= 2'd0;
            asm_q <= '0;
         end else begin
            case (state)
               COLLECT: begin
                  if (accept) begin
                     cnt <= cnt + 2'd1;
                     case (cnt)
                        2'd0: asm_q[F0_HI:F0_LO] <= in_data[6:0];
                        2'd1: asm_q[F1_HI:F1_LO] <= in_data[12:0];
                        2'd2: asm_q[F2_HI:F2_LO] <= in_data[12:0];
                        default: begin
                           if (!z_valid || z_ready) begin
                              z       <= word_done;
                              z_valid <= 1'b1;
                           end else begin
                              asm_q <= word_done;
                              state <= FULL;
                           end
                        end
                     endcase
                  end
               end
               FULL: begin
                  if (drain) begin
                     z       <= asm_q;
                     z_valid <= 1'b1;
                     state   <= COLLECT;
                     cnt     <= 2'd0;
                  end
               end
               default: begin
                  state <= COLLECT;
               end
            endcase
         end
      end
   end

`ifdef Z_PACK_RANGE_CHK_EN
   logic over_range;

   // Bits above the current field width that would be lost by truncation.
   always_comb begin
      over_range = 1'b0;
      case (cnt)
         2'd0:    over_range = |in_data[DW:7];
         2'd1:    over_range = |in_data[DW:13];
         2'd2:    over_range = |in_data[DW:13];
         default: over_range = 1'b0;
      endcase
   end

   // Sticky range-violation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (clr) begin
         err <= 1'b0;
      end else if (accept && over_range) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_z_pack.sv
// Testbench for z_pack: directed scenarios plus a randomized phase, checked by
// a word-level scoreboard that tracks completed words waiting in the packer.
module tb_z_pack;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [32:0]   in_data;
   logic [65:0]   z;
   logic          z_valid;
   logic          z_ready;
   logic          err;
   logic          dbg_full;
   logic [1:0]    dbg_cnt;

`ifdef Z_PACK_RANGE_CHK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model state: completed undrained words, and the partial word.
   logic [65:0] exp_q[$];
   logic [32:0] fld[4];
   int          nf    = 0;
   logic        err_m = 1'b0;

   z_pack dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .z        (z),
      .z_valid  (z_valid),
      .z_ready  (z_ready),
      .err      (err),
      .dbg_full (dbg_full),
      .dbg_cnt  (dbg_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, act=running req=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [65:0] pack(input logic [32:0] a, input logic [32:0] b,
                                        input logic [32:0] c, input logic [32:0] d);
      return {a[6:0], b[12:0], c[12:0], d};
   endfunction

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [32:0] d);
      bit done;
      int waited;
      in_valid = 1'b1;
      in_data  = d;
      done     = 1'b0;
      waited   = 0;
      while (!done) begin
         @(negedge clk);
         done = in_ready && !clr;
         @(posedge clk);
         #1;
         waited++;
         if (!done && waited >= 50) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got=stalled expected=accepted within 50 cycles");
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [32:0] a, input logic [32:0] b,
                            input logic [32:0] c, input logic [32:0] d);
      send_beat(a);
      send_beat(b);
      send_beat(c);
      send_beat(d);
   endtask

   task automatic pulse_clr(input bit with_valid, input logic [32:0] d);
      clr      = 1'b1;
      in_valid = with_valid;
      in_data  = d;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      bit          exp_rdy;
      bit          full_before;
      int          w;
      if (!rst_n) begin
         exp_q.delete();
         nf    = 0;
         err_m = 1'b0;
      end else begin
         exp_rdy = !clr && (exp_q.size() < 2);
         check("in_ready", 66'(in_ready), 66'(exp_rdy));
         check("z_valid", 66'(z_valid), 66'(exp_q.size() > 0));
         check("err", 66'(err), 66'(err_m));
         full_before = (exp_q.size() == 2);
         if (exp_q.size() > 0 && z_ready) begin
            check("z_word", z, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (clr) begin
            if (full_before) void'(exp_q.pop_back());
            nf    = 0;
            err_m = 1'b0;
         end else if (in_valid && exp_rdy) begin
            w = (nf == 0) ? 7 : 13;
            if (RANGE_CHK && nf < 3 && (in_data >> w) != 33'd0) err_m = 1'b1;
            fld[nf] = in_data;
            nf++;
            if (nf == 4) begin
               exp_q.push_back(pack(fld[0], fld[1], fld[2], fld[3]));
               nf = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [32:0] a0, a1, a2, a3, b0, b1, b2, b3;
      int          c0;
      rst_n    = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      z_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_z", z, 66'd0);
      check("reset_cnt", 66'(dbg_cnt), 66'd0);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", 66'(in_ready), 66'd1);
      idle(1);

      // Known word, output free
      z_ready = 1'b1;
      send_word(33'h55, 33'h1ABC, 33'h0123, 33'h1_2345_6789);
      check("known_word", z, {7'h55, 13'h1ABC, 13'h0123, 33'h1_2345_6789});
      check("known_valid", 66'(z_valid), 66'd1);
      idle(2);

      // Two words into a stalled output -> FULL
      z_ready = 1'b0;
      a0 = 33'($urandom); a1 = 33'($urandom); a2 = 33'($urandom); a3 = {1'b1, 32'($urandom)};
      b0 = 33'($urandom); b1 = 33'($urandom); b2 = 33'($urandom); b3 = {1'b0, 32'($urandom)};
      send_word(a0, a1, a2, a3);
      send_word(b0, b1, b2, b3);
      check("full_z_is_a", z, pack(a0, a1, a2, a3));
      check("full_in_ready", 66'(in_ready), 66'd0);
      check("full_state", 66'(dbg_full), 66'd1);
      z_ready = 1'b1;
      idle(1);
      z_ready = 1'b0;
      check("full_z_is_b", z, pack(b0, b1, b2, b3));
      check("full_valid_held", 66'(z_valid), 66'd1);
      check("full_ready_back", 66'(in_ready), 66'd1);
      z_ready = 1'b1;
      idle(3);

      // Flush mid-word, with a beat offered during clr
      send_beat(33'h7F);
      send_beat(33'h1FFF);
      pulse_clr(1'b1, 33'h1_FFFF_FFFF);
      check("clr_cnt", 66'(dbg_cnt), 66'd0);
      send_word(33'h12, 33'h0AAA, 33'h1555, 33'h0_DEAD_BEEF);
      check("clr_fresh_word", z, pack(33'h12, 33'h0AAA, 33'h1555, 33'h0_DEAD_BEEF));
      idle(2);

      // Range violation on beat0
      send_beat(33'h80);
      check("range_err", 66'(err), 66'(RANGE_CHK));
      send_beat(33'h3);
      send_beat(33'h4);
      send_beat(33'h5);
      check("range_trunc", 66'(z[65:59]), 66'd0);
      idle(1);
      pulse_clr(1'b0, 33'd0);
      check("range_err_clr", 66'(err), 66'd0);
      idle(2);

      // Asynchronous reset while FULL
      z_ready = 1'b0;
      send_word(33'h11, 33'h22, 33'h33, 33'h44);
      send_word(33'h55, 33'h66, 33'h77, 33'h88);
      check("pre_rst_full", 66'(dbg_full), 66'd1);
      rst_n = 1'b0;
      #1;
      check("arst_z", z, 66'd0);
      check("arst_valid", 66'(z_valid), 66'd0);
      check("arst_cnt", 66'(dbg_cnt), 66'd0);
      check("arst_state", 66'(dbg_full), 66'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("arst_in_ready", 66'(in_ready), 66'd1);
      z_ready = 1'b1;
      idle(2);

      // Back-to-back words, no stalls expected
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
         send_word(33'($urandom), 33'($urandom_range(0, 8191)),
                   33'($urandom_range(0, 8191)), {1'($urandom), 32'($urandom)});
      end
      check("b2b_cycles", 66'(cyc - c0), 66'd12);
      idle(2);

      // Randomized traffic with random backpressure and occasional flush
      for (int k = 0; k < 600; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) in_data = 33'($urandom_range(0, 127));
         else                           in_data = {1'($urandom), 32'($urandom)};
         z_ready  = ($urandom_range(0, 2) != 0);
         clr      = ($urandom_range(0, 40) == 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      clr      = 1'b0;
      z_ready  = 1'b1;
      idle(6);
      check("drain_empty", 66'(exp_q.size()), 66'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
